// File: rtl/subset_cfg_loader_if.sv
// Byte-stream handshake carrying configuration packets into the loader.
// A byte transfers on a rising edge where in_valid and in_ready are both high.
interface subset_cfg_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/subset_cfg_loader.sv
// Receives framed 8-byte circle configuration packets, validates them and
// commits centres, squared radii and mode to the evaluator bus in one edge.
module subset_cfg_loader #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    subset_cfg_loader_if.slave  in_bus,
    output logic [23:0]         central,
    output logic [23:0]         radius_square,
    output logic [1:0]          mode,
    output logic                cfg_valid,
    output logic                update,
    output logic                err,
    output logic                busy,
    output logic [1:0]          fsm_state
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, COMMIT = 2'd2} state_t;

    state_t        state;
    logic [2:0]    count;
    logic [TW-1:0] tcnt;
    logic [1:0]    mode_sh;
    logic [23:0]   cen_sh;
    logic [11:0]   rad_sh;
    logic          xfer;
    logic          bad_byte;

    function automatic logic [7:0] sq(input logic [3:0] r);
        return {4'b0, r} * {4'b0, r};
    endfunction

    assign xfer      = in_bus.in_valid & in_bus.in_ready;
    assign fsm_state = state;

    // count indexes the payload: 0 is the mode byte, 4..6 are the radii.
    always_comb begin
        bad_byte = 1'b0;
        if (count == 3'd0)
            bad_byte = (in_bus.in_data[7:2] != 6'd0);
        else if (count >= 3'd4)
            bad_byte = (in_bus.in_data[7:4] != 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= '0;
            tcnt            <= '0;
            mode_sh         <= '0;
            cen_sh          <= '0;
            rad_sh          <= '0;
            central         <= '0;
            radius_square   <= '0;
            mode            <= '0;
            cfg_valid       <= 1'b0;
            update          <= 1'b0;
            err             <= 1'b0;
            busy            <= 1'b0;
            in_bus.in_ready <= 1'b0;
        end else begin
            update          <= 1'b0;
            err             <= 1'b0;
            in_bus.in_ready <= 1'b1;
            case (state)
                IDLE: begin
                    if (xfer && in_bus.in_data == HEADER) begin
                        state <= RECV;
                        busy  <= 1'b1;
                        count <= '0;
                        tcnt  <= '0;
                    end
                end
                RECV: begin
                    if (xfer) begin
                        tcnt  <= '0;
                        count <= count + 3'd1;
                        if (bad_byte) begin
                            err   <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            case (count)
                                3'd0:    mode_sh        <= in_bus.in_data[1:0];
                                3'd1:    cen_sh[23:16]  <= in_bus.in_data;
                                3'd2:    cen_sh[15:8]   <= in_bus.in_data;
                                3'd3:    cen_sh[7:0]    <= in_bus.in_data;
                                3'd4:    rad_sh[11:8]   <= in_bus.in_data[3:0];
                                3'd5:    rad_sh[7:4]    <= in_bus.in_data[3:0];
                                default: rad_sh[3:0]    <= in_bus.in_data[3:0];
                            endcase
                            if (count == 3'd6) begin
                                state           <= COMMIT;
                                in_bus.in_ready <= 1'b0;
                            end
                        end
                    end else if (tcnt == T_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                COMMIT: begin
                    central       <= cen_sh;
                    radius_square <= {sq(rad_sh[11:8]), sq(rad_sh[7:4]), sq(rad_sh[3:0])};
                    mode          <= mode_sh;
                    update        <= 1'b1;
                    cfg_valid     <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
